// File: rtl/bus_arb_mux.sv
// ---------------------------------------------------------------------------
// bus_arb_mux
//   Registered N-source bus multiplexer with req/gnt arbitration on the source
//   side and a valid/ready handshake on the bus side. One captured word is
//   driven at a time and held stable until the consumer takes it.
//
//   Configuration macro: BUS_ARB_FIXED_PRI_EN
//     defined   -> fixed priority, lowest set req index wins, no rr pointer
//     undefined -> round-robin starting after the last winner (default)
//
// Ports
//   clk        in   1           clock, all state on rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req        in   NSRC        per-source request (slice i of src_data valid)
//   src_data   in   NSRC*WIDTH  flattened source data, slice i = [i*WIDTH +: WIDTH]
//   gnt        out  NSRC        one-hot one-cycle pulse: source i captured
//   bus_data   out  WIDTH       registered bus word
//   bus_sel    out  SELW        index of the source owning bus_data
//   bus_valid  out  1           bus_data valid
//   bus_ready  in   1           consumer accepts bus_data when valid && ready
// ---------------------------------------------------------------------------
module bus_arb_mux #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic [NSRC-1:0]       gnt,
    output logic [WIDTH-1:0]      bus_data,
    output logic [SELW-1:0]       bus_sel,
    output logic                  bus_valid,
    input  logic                  bus_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_bus_data;
    logic [SELW-1:0]   r_bus_sel;
    logic              r_bus_valid;
    logic [NSRC-1:0]   r_gnt;

    logic [SELW:0]     w_pick;     // {found, index}
    logic              w_any;
    logic [SELW-1:0]   w_win;
    logic              w_capture;

`ifdef BUS_ARB_FIXED_PRI_EN
    // Lowest set request index; returns {found, index}.
    function automatic logic [SELW:0] fixed_pick(input logic [NSRC-1:0] r);
        logic [SELW:0] res;
        res = {1'b0, {SELW{1'b0}}};
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (r[k]) begin
                res = {1'b1, SELW'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Fixed-priority winner selection.
    always_comb begin
        w_pick = fixed_pick(req);
    end
`else
    logic [SELW-1:0] r_rr_ptr;

    // First set request scanning p+1, p+2, ... modulo n; returns {found, index}.
    // The wrap is done explicitly so a non-power-of-two NSRC works.
    function automatic logic [SELW:0] rr_pick(input logic [NSRC-1:0] r,
                                              input logic [SELW-1:0] p);
        logic [SELW:0]   res;
        logic [SELW-1:0] idx;
        int              s;
        res = {1'b0, {SELW{1'b0}}};
        for (int k = 1; k <= NSRC; k++) begin
            s = int'(p) + k;
            if (s >= NSRC) begin
                s = s - NSRC;
            end else begin
                s = s;
            end
            idx = s[SELW-1:0];
            if (!res[SELW] && r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin winner selection.
    always_comb begin
        w_pick = rr_pick(req, r_rr_ptr);
    end

    // Pointer remembers the last winner; reset so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= SELW'(NSRC - 1);
        end else if (w_capture) begin
            r_rr_ptr <= w_win;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    assign w_any = w_pick[SELW];
    assign w_win = w_pick[SELW-1:0];

    // A capture happens from IDLE, or from BUSY on the edge the word is taken.
    assign w_capture = w_any && ((r_state == ST_IDLE) || bus_ready);

    // Control FSM with registered bus outputs and grant pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bus_data  <= {WIDTH{1'b0}};
            r_bus_sel   <= {SELW{1'b0}};
            r_bus_valid <= 1'b0;
            r_gnt       <= {NSRC{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_bus_data  <= src_data[w_win*WIDTH +: WIDTH];
                        r_bus_sel   <= w_win;
                        r_bus_valid <= 1'b1;
                        r_gnt       <= {{(NSRC-1){1'b0}}, 1'b1} << w_win;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_gnt       <= {NSRC{1'b0}};
                        r_state     <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!bus_ready) begin
                        // Stall: hold the word, ignore new requests.
                        r_gnt       <= {NSRC{1'b0}};
                    end else if (w_any) begin
                        // Word taken this edge; next one captured with no bubble.
                        r_bus_data  <= src_data[w_win*WIDTH +: WIDTH];
                        r_bus_sel   <= w_win;
                        r_bus_valid <= 1'b1;
                        r_gnt       <= {{(NSRC-1){1'b0}}, 1'b1} << w_win;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_bus_valid <= 1'b0;
                        r_gnt       <= {NSRC{1'b0}};
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_gnt       <= {NSRC{1'b0}};
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign bus_data  = r_bus_data;
    assign bus_sel   = r_bus_sel;
    assign bus_valid = r_bus_valid;

endmodule

// File: tb/tb_bus_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_bus_arb_mux
//   Directed self-checking bench for bus_arb_mux (WIDTH=16, NSRC=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_bus_arb_mux;

    localparam int WIDTH = 16;
    localparam int NSRC  = 4;
    localparam int SELW  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NSRC-1:0]       req;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       gnt;
    logic [WIDTH-1:0]      bus_data;
    logic [SELW-1:0]       bus_sel;
    logic                  bus_valid;
    logic                  bus_ready;

    int checks;
    int errors;

    bus_arb_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .src_data  (src_data),
        .gnt       (gnt),
        .bus_data  (bus_data),
        .bus_sel   (bus_sel),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b1111;
        bus_ready = 1'b1;
        tick();
        tick();
        checks += 4;
        if (bus_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b want 0", bus_valid); end
        if (bus_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus_data); end
        if (bus_sel !== 2'd0)      begin errors++; $display("FAIL reset_sel got %0d want 0", bus_sel); end
        if (gnt !== 4'b0000)       begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_req();
        req       = 4'b0100;
        bus_ready = 1'b1;
        tick();
        req = 4'b0000;
        checks += 4;
        if (bus_valid !== 1'b1)    begin errors++; $display("FAIL single_valid got %b want 1", bus_valid); end
        if (bus_data !== 16'hCCCC) begin errors++; $display("FAIL single_data got %h want CCCC", bus_data); end
        if (bus_sel !== 2'd2)      begin errors++; $display("FAIL single_sel got %0d want 2", bus_sel); end
        if (gnt !== 4'b0100)       begin errors++; $display("FAIL single_gnt got %b want 0100", gnt); end
        tick();
        checks += 2;
        if (bus_valid !== 1'b0)    begin errors++; $display("FAIL single_drop got %b want 0", bus_valid); end
        if (gnt !== 4'b0000)       begin errors++; $display("FAIL single_gnt_end got %b want 0000", gnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [5];
        logic [1:0]  exp_s [5];
        exp_d = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hAAAA};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req       = 4'b1111;
        bus_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 4;
            if (bus_valid !== 1'b1)    begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, bus_valid); end
            if (bus_data !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus_data, exp_d[i]); end
            if (bus_sel !== exp_s[i])  begin errors++; $display("FAIL b2b_sel[%0d] got %0d want %0d", i, bus_sel, exp_s[i]); end
            if (gnt !== (4'b0001 << exp_s[i])) begin errors++; $display("FAIL b2b_gnt[%0d] got %b want %b", i, gnt, 4'b0001 << exp_s[i]); end
        end
        req = 4'b0000;
        tick();
        checks += 1;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", bus_valid); end
    endtask

    task automatic test_stall();
        int pulses;
        pulses    = 0;
        req       = 4'b0010;
        bus_ready = 1'b0;
        tick();
        if (gnt === 4'b0010) pulses++;
        checks += 1;
        if (bus_data !== 16'hBBBB) begin errors++; $display("FAIL stall_capture got %h want BBBB", bus_data); end
        src_data[1*WIDTH +: WIDTH] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt !== 4'b0000) pulses++;
            checks += 2;
            if (bus_data !== 16'hBBBB) begin errors++; $display("FAIL stall_hold[%0d] got %h want BBBB", i, bus_data); end
            if (bus_valid !== 1'b1)    begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus_valid); end
        end
        checks += 1;
        if (pulses != 1) begin errors++; $display("FAIL stall_gnt_pulses got %0d want 1", pulses); end
        bus_ready = 1'b1;
        tick();
        req = 4'b0000;
        checks += 3;
        if (bus_data !== 16'h1234) begin errors++; $display("FAIL stall_new_data got %h want 1234", bus_data); end
        if (bus_sel !== 2'd1)      begin errors++; $display("FAIL stall_new_sel got %0d want 1", bus_sel); end
        if (gnt !== 4'b0010)       begin errors++; $display("FAIL stall_new_gnt got %b want 0010", gnt); end
        tick();
        src_data[1*WIDTH +: WIDTH] = 16'hBBBB;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req       = 4'b1000;
        bus_ready = 1'b0;
        tick();
        checks += 1;
        if (bus_data !== 16'hDDDD) begin errors++; $display("FAIL mid_setup got %h want DDDD", bus_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus_valid !== 1'b0)    begin errors++; $display("FAIL mid_valid got %b want 0", bus_valid); end
        if (bus_data !== 16'h0000) begin errors++; $display("FAIL mid_data got %h want 0000", bus_data); end
        if (gnt !== 4'b0000)       begin errors++; $display("FAIL mid_gnt got %b want 0000", gnt); end
        rst_n     = 1'b1;
        req       = 4'b1111;
        bus_ready = 1'b1;
        tick();
        req = 4'b0000;
        checks += 3;
        if (bus_sel !== 2'd0)      begin errors++; $display("FAIL mid_first_sel got %0d want 0", bus_sel); end
        if (bus_data !== 16'hAAAA) begin errors++; $display("FAIL mid_first_data got %h want AAAA", bus_data); end
        if (gnt !== 4'b0001)       begin errors++; $display("FAIL mid_first_gnt got %b want 0001", gnt); end
        tick();
    endtask

    task automatic test_single_repeat();
        do_reset();
        req       = 4'b0001;
        bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (bus_data !== 16'hAAAA) begin errors++; $display("FAIL repeat_data[%0d] got %h want AAAA", i, bus_data); end
            if (gnt !== 4'b0001)       begin errors++; $display("FAIL repeat_gnt[%0d] got %b want 0001", i, gnt); end
            if (bus_valid !== 1'b1)    begin errors++; $display("FAIL repeat_valid[%0d] got %b want 1", i, bus_valid); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_req_1011();
        logic [1:0]  exp_s [4];
        logic [15:0] exp_d [4];
`ifdef BUS_ARB_FIXED_PRI_EN
        exp_s = '{2'd0, 2'd0, 2'd0, 2'd0};
        exp_d = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
`else
        exp_s = '{2'd0, 2'd1, 2'd3, 2'd0};
        exp_d = '{16'hAAAA, 16'hBBBB, 16'hDDDD, 16'hAAAA};
`endif
        do_reset();
        req       = 4'b1011;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (bus_sel !== exp_s[i])  begin errors++; $display("FAIL p1011_sel[%0d] got %0d want %0d", i, bus_sel, exp_s[i]); end
            if (bus_data !== exp_d[i]) begin errors++; $display("FAIL p1011_data[%0d] got %h want %h", i, bus_data, exp_d[i]); end
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        bus_ready = 1'b0;
        src_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        test_reset();
        test_single_req();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_single_repeat();
        test_req_1011();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
